// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port Memoria: serialises CPU and loader/DMA accesses,
// inserts read wait-states for the registered read latency and returns data with a done pulse.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              arb_valid;
    logic              arb_win;

    // Tie goes to port 0 under fixed priority, otherwise to the port not served last.
    always_comb begin
        arb_valid = req0 | req1;
        if (req0 && req1) begin
            arb_win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end else begin
            arb_win = req1;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (arb_valid) begin
                    state_d = ACCESS;
                    owner_d = arb_win;
                    last_d  = arb_win;
                    we_d    = arb_win ? we1 : we0;
                    addr_d  = arb_win ? addr1 : addr0;
                    wdata_d = arb_win ? wdata1 : wdata0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = LAT;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Everything below is decoded from registered state only.
    always_comb begin
        gnt0      = (state_q == ACCESS) && !owner_q;
        gnt1      = (state_q == ACCESS) && owner_q;
        done0     = (state_q == DONE) && !owner_q;
        done1     = (state_q == DONE) && owner_q;
        busy      = (state_q != IDLE);
        mem_wr    = (state_q == ACCESS) && we_q;
        mem_addr  = ((state_q == ACCESS) || (state_q == RD_WAIT)) ? addr_q : '0;
        mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
        rdata     = rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three parameterisations driven side by side, checked every cycle
// against a transaction-timeline model, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int NI = 3;  // 0: RD_LAT=1 round-robin, 1: RD_LAT=1 fixed, 2: RD_LAT=3 round-robin

    logic        Clk;
    logic        reset;
    logic        req0 [NI];
    logic        we0 [NI];
    logic [31:0] addr0 [NI];
    logic [31:0] wdata0 [NI];
    logic        gnt0 [NI];
    logic        done0 [NI];
    logic        req1 [NI];
    logic        we1 [NI];
    logic [31:0] addr1 [NI];
    logic [31:0] wdata1 [NI];
    logic        gnt1 [NI];
    logic        done1 [NI];
    logic [31:0] rdata [NI];
    logic        busy [NI];
    logic [31:0] mem_addr [NI];
    logic        mem_wr [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W    (32),
            .DATA_W    (32),
            .RD_LAT    ((g == 2) ? 3 : 1),
            .FIXED_PRIO((g == 1) ? 1 : 0)
        ) u_dut (
            .Clk      (Clk),
            .reset    (reset),
            .req0     (req0[g]),
            .we0      (we0[g]),
            .addr0    (addr0[g]),
            .wdata0   (wdata0[g]),
            .gnt0     (gnt0[g]),
            .done0    (done0[g]),
            .req1     (req1[g]),
            .we1      (we1[g]),
            .addr1    (addr1[g]),
            .wdata1   (wdata1[g]),
            .gnt1     (gnt1[g]),
            .done1    (done1[g]),
            .rdata    (rdata[g]),
            .busy     (busy[g]),
            .mem_addr (mem_addr[g]),
            .mem_wr   (mem_wr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata)
        );
    end

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic int lat_of(int i);
        return (i == 2) ? 3 : 1;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %h, expected %h", name, inst, got, want);
        end
    endtask

    // Model: a granted transaction occupies cycles k = 0 (access) .. len-1 (done).
    bit          m_act [NI];
    int          m_k [NI];
    bit          m_own [NI];
    bit          m_we [NI];
    bit          m_last [NI];
    logic [31:0] m_addr [NI];
    logic [31:0] m_wdata [NI];
    logic [31:0] m_rdata [NI];

    always @(negedge Clk) begin : model
        int  len;
        int  lat;
        bit  in_acc;
        bit  in_done;
        bit  win;
        for (int i = 0; i < NI; i++) begin
            lat = lat_of(i);
            len = m_we[i] ? 2 : lat + 2;
            if (!reset) begin
                chk("rst_gnt0", i, gnt0[i], 0);
                chk("rst_gnt1", i, gnt1[i], 0);
                chk("rst_done0", i, done0[i], 0);
                chk("rst_done1", i, done1[i], 0);
                chk("rst_busy", i, busy[i], 0);
                chk("rst_mem_wr", i, mem_wr[i], 0);
                chk("rst_mem_addr", i, mem_addr[i], 0);
                chk("rst_rdata", i, rdata[i], 0);
                m_act[i]   = 1'b0;
                m_last[i]  = 1'b1;
                m_rdata[i] = '0;
            end else begin
                in_acc  = m_act[i] && (m_k[i] == 0);
                in_done = m_act[i] && (m_k[i] == len - 1);
                chk("gnt0", i, gnt0[i], in_acc && !m_own[i]);
                chk("gnt1", i, gnt1[i], in_acc && m_own[i]);
                chk("done0", i, done0[i], in_done && !m_own[i]);
                chk("done1", i, done1[i], in_done && m_own[i]);
                chk("busy", i, busy[i], m_act[i]);
                chk("mem_wr", i, mem_wr[i], in_acc && m_we[i]);
                chk("rdata", i, rdata[i], m_rdata[i]);
                if (m_act[i] && (m_k[i] < len - 1)) chk("mem_addr", i, mem_addr[i], m_addr[i]);
                if (in_acc && m_we[i]) chk("mem_wdata", i, mem_wdata[i], m_wdata[i]);
                if (m_act[i] && !m_we[i] && (m_k[i] == lat)) m_rdata[i] = mem_rdata;
                if (!m_act[i] || in_done) begin
                    if (req0[i] || req1[i]) begin
                        if (req0[i] && req1[i]) win = (i == 1) ? 1'b0 : !m_last[i];
                        else win = req1[i];
                        m_act[i]   = 1'b1;
                        m_k[i]     = 0;
                        m_own[i]   = win;
                        m_last[i]  = win;
                        m_we[i]    = win ? we1[i] : we0[i];
                        m_addr[i]  = win ? addr1[i] : addr0[i];
                        m_wdata[i] = win ? wdata1[i] : wdata0[i];
                    end else begin
                        m_act[i] = 1'b0;
                    end
                end else begin
                    m_k[i]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_p0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < NI; i++) begin
            req0[i] = r; we0[i] = w; addr0[i] = a; wdata0[i] = d;
        end
    endtask

    task automatic set_p1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < NI; i++) begin
            req1[i] = r; we1[i] = w; addr1[i] = a; wdata1[i] = d;
        end
    endtask

    // Random requester obeying the hold-until-grant protocol, with occasional withdrawal.
    task automatic next_req(input logic g, input logic r_in, input logic w_in,
                            input logic [31:0] a_in, input logic [31:0] d_in,
                            output logic r, output logic w, output logic [31:0] a,
                            output logic [31:0] d);
        bit fresh;
        r = r_in; w = w_in; a = a_in; d = d_in;
        fresh = 1'b0;
        if (r_in && g) begin
            if ($urandom_range(0, 3) == 0) fresh = 1'b1;
            else r = 1'b0;
        end else if (r_in) begin
            if ($urandom_range(0, 15) == 0) r = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            fresh = 1'b1;
        end
        if (fresh) begin
            r = 1'b1;
            w = 1'($urandom_range(0, 1));
            a = $urandom & 32'h0000_00ff;
            d = $urandom;
        end
    endtask

    logic [7:0] h_g0 [NI];
    logic [7:0] h_g1 [NI];
    logic       seen;
    logic       r, w;
    logic [31:0] a, d;

    initial begin
        reset = 1'b0;
        mem_rdata = '0;
        set_p0(0, 0, 0, 0);
        set_p1(0, 0, 0, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Port 0 read of 0x10.
        set_p0(1, 0, 32'h10, 0);
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("t1_gnt0_c1", 0, gnt0[0], 1);
        chk("t1_addr_c1", 0, mem_addr[0], 32'h10);
        chk("t1_gnt1_c1", 0, gnt1[0], 0);
        set_p0(0, 0, 0, 0);
        tick();
        chk("t1_addr_c2", 0, mem_addr[0], 32'h10);
        chk("t1_done0_c2", 0, done0[0], 0);
        tick();
        chk("t1_done0_c3", 0, done0[0], 1);
        chk("t1_rdata_c3", 0, rdata[0], 32'hDEAD_BEEF);
        chk("t1_done1_c3", 0, done1[0], 0);
        chk("t1_lat3_addr_c3", 2, mem_addr[2], 32'h10);
        tick();
        mem_rdata = 32'hCAFE_F00D;
        chk("t1_lat3_done_c4", 2, done0[2], 0);
        chk("t1_lat3_busy_c4", 2, busy[2], 1);
        tick();
        chk("t1_lat3_done_c5", 2, done0[2], 1);
        chk("t1_lat3_rdata_c5", 2, rdata[2], 32'hCAFE_F00D);
        mem_rdata = 32'h1111_1111;
        tick();

        // Port 1 write of 0x12345678 to 0x20.
        set_p1(1, 1, 32'h20, 32'h1234_5678);
        tick();
        chk("t2_gnt1", 0, gnt1[0], 1);
        chk("t2_mem_wr_c1", 0, mem_wr[0], 1);
        chk("t2_addr", 0, mem_addr[0], 32'h20);
        chk("t2_wdata", 0, mem_wdata[0], 32'h1234_5678);
        set_p1(0, 0, 0, 0);
        tick();
        chk("t2_mem_wr_c2", 0, mem_wr[0], 0);
        chk("t2_done1", 0, done1[0], 1);
        chk("t2_rdata_kept", 0, rdata[0], 32'hDEAD_BEEF);
        chk("t2_rdata_kept", 2, rdata[2], 32'hCAFE_F00D);
        tick();

        // Both ports reading continuously.
        set_p0(1, 0, 32'h40, 0);
        set_p1(1, 0, 32'h44, 0);
        for (int i = 0; i < NI; i++) begin
            h_g0[i] = '0; h_g1[i] = '0;
        end
        for (int c = 1; c <= 7; c++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                h_g0[i][c] = gnt0[i];
                h_g1[i][c] = gnt1[i];
            end
        end
        set_p0(0, 0, 0, 0);
        set_p1(0, 0, 0, 0);
        chk("t3_rr_gnt0", 0, 32'(h_g0[0]), 32'h82);
        chk("t3_rr_gnt1", 0, 32'(h_g1[0]), 32'h10);
        chk("t3_fp_gnt0", 1, 32'(h_g0[1]), 32'h92);
        chk("t3_fp_gnt1", 1, 32'(h_g1[1]), 32'h00);
        chk("t3_lat3_gnt1", 2, 32'(h_g1[2]), 32'h40);
        repeat (8) tick();

        // Reset during a port 1 read wait.
        set_p1(1, 0, 32'h80, 0);
        tick();
        chk("t4_gnt1", 0, gnt1[0], 1);
        set_p1(0, 0, 0, 0);
        tick();
        chk("t4_busy_wait", 0, busy[0], 1);
        #1 reset = 1'b0;
        #1;
        chk("t4_rst_busy", 0, busy[0], 0);
        chk("t4_rst_addr", 0, mem_addr[0], 0);
        chk("t4_rst_rdata", 0, rdata[0], 0);
        chk("t4_rst_busy_lat3", 2, busy[2], 0);
        set_p0(1, 0, 32'h90, 0);
        set_p1(1, 0, 32'h94, 0);
        tick();
        tick();
        chk("t4_no_done1", 0, done1[0], 0);
        reset = 1'b1;
        tick();
        chk("t4_tie_gnt0", 0, gnt0[0], 1);
        chk("t4_tie_gnt1", 0, gnt1[0], 0);
        set_p0(0, 0, 0, 0);
        set_p1(0, 0, 0, 0);
        repeat (8) tick();

        // Port 0 request withdrawn before the port 1 done cycle ends.
        set_p1(1, 1, 32'h30, 32'hA5A5_A5A5);
        tick();
        chk("t5_gnt1", 0, gnt1[0], 1);
        set_p1(0, 0, 0, 0);
        set_p0(1, 0, 32'h55, 0);
        tick();
        chk("t5_done1", 0, done1[0], 1);
        set_p0(0, 0, 0, 0);
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int i = 0; i < NI; i++) seen = seen | gnt0[i] | busy[i];
        end
        chk("t5_withdrawn", 0, seen, 0);

        // Random traffic with one reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c == 1500) reset = 1'b0;
            if (c == 1503) reset = 1'b1;
            mem_rdata = $urandom;
            for (int i = 0; i < NI; i++) begin
                next_req(gnt0[i], req0[i], we0[i], addr0[i], wdata0[i], r, w, a, d);
                req0[i] = r; we0[i] = w; addr0[i] = a; wdata0[i] = d;
                next_req(gnt1[i], req1[i], we1[i], addr1[i], wdata1[i], r, w, a, d);
                req1[i] = r; we1[i] = w; addr1[i] = a; wdata1[i] = d;
            end
        end
        set_p0(0, 0, 0, 0);
        set_p1(0, 0, 0, 0);
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port Memoria between two requesters: port 0 is the CPU multicycle datapath (instruction fetch and load/store); port 1 is a loader/DMA engine.
- Serialises accesses, generates read wait-states for the memory's registered read latency, and returns read data with a one-cycle done pulse.
- Sits between the datapath's Address/WriteDataMem/wr path and the Memoria instance.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles (1..7).
- FIXED_PRIO, 0. 0 = round-robin between ports; 1 = port 0 always wins a tie.

Ports:
- Clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 access request (level).
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 request accepted (1-cycle pulse).
- done0  out  1  port 0 access complete (1-cycle pulse).
- req1, we1, addr1, wdata1, gnt1, done1: same meanings for port 1.
- rdata  out  DATA_W  read data, shared; valid while done0 or done1 is high after a read.
- busy  out  1  high in any state other than IDLE.
- mem_addr  out  ADDR_W  memory address.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, all outputs 0 (including mem_wr), last_srv=1, wait counter=0.
  - An in-flight access is aborted; no done pulse is produced for it.
- States: IDLE, ACCESS, RD_WAIT, DONE. All outputs are registered or decoded from the state only; none depend combinationally on req.
- Arbitration happens in IDLE and DONE.
  - If exactly one req is high, that port wins.
  - If both are high: with FIXED_PRIO=1, port 0 wins; otherwise the port != last_srv wins.
- On a win, at the clock edge:
  - latch the winner's we, addr and wdata;
  - set owner and last_srv to the winner;
  - go to ACCESS.
- With no req, IDLE stays in IDLE and DONE goes to IDLE.
- ACCESS (exactly 1 cycle):
  - gnt of the owner = 1.
  - mem_addr = latched address.
  - mem_wr = latched we; this is the only cycle mem_wr can be 1.
  - mem_wdata = latched wdata.
  - Write: go to DONE. Read: load counter with RD_LAT and go to RD_WAIT.
- RD_WAIT:
  - mem_addr is held and mem_wr=0; the counter decrements each cycle.
  - In the cycle the counter equals 1, mem_rdata is captured into rdata at the edge and the state goes to DONE.
  - Duration is exactly RD_LAT cycles.
- DONE (exactly 1 cycle):
  - done of the owner = 1.
  - rdata holds the captured value for a read; it is unchanged after a write.
  - Arbitration proceeds in the same cycle, allowing back-to-back accesses without passing through IDLE.
- Latency from req sampled high (cycle 0), when idle and uncontested:
  - write: gnt in cycle 1, done in cycle 2;
  - read: gnt in cycle 1, done in cycle 2+RD_LAT.
- Requester protocol:
  - hold req, we, addr and wdata stable until gnt is seen;
  - deassert req in the cycle after gnt unless a new access is intended.
  - req dropped before gnt means the request is withdrawn with no access; this is legal.
- gnt0 and gnt1 are never high together. The same holds for done0/done1.
- rdata is retained until the next read capture or reset.
- Starvation bound with FIXED_PRIO=0: a continuously requesting port is granted within one foreign transaction.

Test Plan:
- Reset, then port 0 read addr 0x10 with mem_rdata=0xDEADBEEF, RD_LAT=1 -> gnt0 in cycle 1, mem_addr=0x10 in cycles 1-2, done0 in cycle 3, rdata=0xDEADBEEF, gnt1 and done1 stay 0.
- Port 1 write addr 0x20, data 0x12345678 -> mem_wr=1 for exactly cycle 1 with mem_addr=0x20 and mem_wdata=0x12345678; done1 in cycle 2; rdata unchanged.
- Both ports request reads continuously, FIXED_PRIO=0 -> grants alternate 0,1,0,1 starting with port 0, one access every 3 cycles with RD_LAT=1. Repeat with FIXED_PRIO=1 -> only port 0 is granted.
- RD_LAT=3, port 0 read -> RD_WAIT lasts 3 cycles, done0 in cycle 5, rdata equals mem_rdata sampled in cycle 4.
- Assert reset during the RD_WAIT of a port 1 read -> outputs go to 0 immediately, no done1, and after release a port 0 tie is won by port 0.
- Port 0 raises req then drops it before the arbiter leaves DONE of a port 1 access -> no gnt0 and no memory access for port 0.
